// File: rtl/ir_pkg.sv
// Shared types and constants for the IR dispatch queue.
//   dram_word_t : one dispatch RAM word {A[0:2], B[0:2], P, J[1:4], J[7:10]}
//   ir_entry_t  : one decoded queue entry as presented at the queue head
//   dispatch_addr() : IR -> dispatch RAM address, including the 7xx remap
//   to_word()       : raw RAM bits -> dram_word_t using the field offsets
// IR bit k (IR[0] = MSB) lives at vector index 12-k throughout.
package ir_pkg;

  localparam int unsigned DRAM_WIDTH = 15;

  // Field offsets inside a raw dispatch word (LSB index of each field).
  localparam int unsigned DRAM_A_LSB    = 12;
  localparam int unsigned DRAM_B_LSB    = 9;
  localparam int unsigned DRAM_P_BIT    = 8;
  localparam int unsigned DRAM_J14_LSB  = 4;
  localparam int unsigned DRAM_J710_LSB = 0;

  localparam logic [8:0] JRST_OPC  = 9'o254;
  localparam logic [2:0] IO_OPC_HI = 3'o7;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       p;
    logic [3:0] j14;
    logic [3:0] j710;
  } dram_word_t;

  typedef struct packed {
    logic [12:0] ir;
    logic [3:0]  ac;
    logic [2:0]  dram_a;
    logic [2:0]  dram_b;
    logic [7:0]  dram_j;
    logic        jrst0;
    logic        par_bad;
  } ir_entry_t;

  // 7xx (I/O) opcodes fold the device field into the middle octal digit:
  // any nonzero IR[3:6] saturates it to 7, otherwise IR[7:9] passes through.
  function automatic logic [8:0] dispatch_addr(logic [12:0] ir, logic en_io_jrst);
    if (en_io_jrst && (ir[12:10] == IO_OPC_HI)) begin
      return {ir[12:10], {3{|ir[9:6]}} | ir[5:3], ir[2:0]};
    end
    return ir[12:4];
  endfunction

  function automatic dram_word_t to_word(logic [DRAM_WIDTH-1:0] raw);
    dram_word_t w;
    w.a    = raw[DRAM_A_LSB +: 3];
    w.b    = raw[DRAM_B_LSB +: 3];
    w.p    = raw[DRAM_P_BIT];
    w.j14  = raw[DRAM_J14_LSB +: 4];
    w.j710 = raw[DRAM_J710_LSB +: 4];
    return w;
  endfunction

endpackage

// File: rtl/ir_dram_ram.sv
// Dispatch RAM: synchronous 1R1W, one-cycle read latency, no reset on contents.
// A write in the same cycle as a read suppresses the read (write priority).
//   i_clk   : clock, rising edge
//   i_we    : write strobe, i_waddr / i_wdata
//   i_re    : read strobe, i_raddr; o_rdata valid the next cycle and held
module ir_dram_ram #(
  parameter int unsigned AddrBits = 9,
  parameter int unsigned Width    = 15
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [AddrBits-1:0] i_waddr,
  input  logic [Width-1:0]    i_wdata,
  input  logic                i_re,
  input  logic [AddrBits-1:0] i_raddr,
  output logic [Width-1:0]    o_rdata
);

  logic [Width-1:0] r_mem [2**AddrBits];
  logic [Width-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ir_dispatch_queue.sv
// IR dispatch queue: an accepted instruction word is registered in stage S1
// while its dispatch RAM word is read, then the decoded entry joins a FIFO.
//   clk, reset            : clock and synchronous active-high reset
//   in_valid/in_ready/in_ir : instruction word handshake, IR[0:12]
//   en_io_jrst, en_ac     : decode enables (7xx remap + JRST detect, AC field)
//   flush                 : drop S1 and all queued entries
//   dw_en/dw_addr/dw_data : dispatch RAM write port
//   out_valid/out_ready   : head handshake; out_* describe the head entry
//   par_err/par_clr       : sticky even-parity error and its clear
//   count                 : number of queued entries (S1 excluded)
module ir_dispatch_queue #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned DRAM_ADDR_BITS = 9,
  parameter int unsigned DRAM_WIDTH     = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [12:0]                in_ir,
  input  logic                       en_io_jrst,
  input  logic                       en_ac,
  input  logic                       flush,
  input  logic                       dw_en,
  input  logic [DRAM_ADDR_BITS-1:0]  dw_addr,
  input  logic [DRAM_WIDTH-1:0]      dw_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [12:0]                out_ir,
  output logic [3:0]                 out_ac,
  output logic [2:0]                 out_dram_a,
  output logic [2:0]                 out_dram_b,
  output logic [7:0]                 out_dram_j,
  output logic                       out_jrst0,
  output logic                       out_par_bad,
  output logic                       par_err,
  input  logic                       par_clr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  import ir_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CntW:0] DepthOcc = DEPTH[CntW:0];

  logic                      w_accept;
  logic                      w_push;
  logic                      w_pop;
  logic [CntW:0]             w_occ;
  logic [DRAM_ADDR_BITS-1:0] w_raddr;
  logic [DRAM_WIDTH-1:0]     w_rdata;
  dram_word_t                w_word;
  logic                      w_s1_jrst;
  ir_entry_t                 w_entry;

  logic                      r_s1_valid;
  logic [12:0]               r_s1_ir;
  logic                      r_s1_en_io_jrst;
  logic                      r_s1_en_ac;

  ir_entry_t                 r_q [DEPTH];
  logic [PtrW-1:0]           r_wptr;
  logic [PtrW-1:0]           r_rptr;
  logic [CntW-1:0]           r_count;
  logic                      r_par_err;

  // S1 is counted as occupied so its entry always has a free slot next cycle;
  // a same-cycle pop deliberately does not open the gate.
  assign w_occ    = {1'b0, r_count} + {{CntW{1'b0}}, r_s1_valid};
  assign in_ready = ~reset & ~flush & ~dw_en & (w_occ < DepthOcc);
  assign w_accept = in_valid & in_ready;
  assign w_push   = r_s1_valid & ~reset & ~flush;
  assign w_pop    = out_valid & out_ready;
  assign w_raddr  = DRAM_ADDR_BITS'(dispatch_addr(in_ir, en_io_jrst));

  ir_dram_ram #(
    .AddrBits (DRAM_ADDR_BITS),
    .Width    (DRAM_WIDTH)
  ) u_dram (
    .i_clk   (clk),
    .i_we    (dw_en),
    .i_waddr (dw_addr),
    .i_wdata (dw_data),
    .i_re    (w_accept),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_word = to_word(w_rdata);

  // Decode the S1 word together with the RAM data read on acceptance.
  always_comb begin
    w_s1_jrst      = r_s1_en_io_jrst & (r_s1_ir[12:4] == JRST_OPC);
    w_entry        = '0;
    w_entry.ir     = r_s1_ir;
    w_entry.ac     = r_s1_en_ac ? r_s1_ir[3:0] : 4'd0;
    w_entry.dram_a = w_word.a;
    w_entry.dram_b = w_word.b;
    // JRST takes J[7:10] from RAM and clears J[4]; otherwise J[7:10] is the AC field.
    w_entry.dram_j = {w_s1_jrst ? {w_word.j14[3:1], 1'b0} : w_word.j14,
                      w_s1_jrst ? w_word.j710 : r_s1_ir[3:0]};
    w_entry.jrst0  = w_s1_jrst & (r_s1_ir[3:0] == 4'd0);
    w_entry.par_bad = ~(^w_word);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_ir         <= '0;
      r_s1_en_io_jrst <= 1'b0;
      r_s1_en_ac      <= 1'b0;
    end else if (w_accept) begin
      r_s1_ir         <= in_ir;
      r_s1_en_io_jrst <= en_io_jrst;
      r_s1_en_ac      <= en_ac;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // Set wins over a simultaneous clear; flush leaves the flag alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_par_err <= 1'b0;
    end else if (w_push && w_entry.par_bad) begin
      r_par_err <= 1'b1;
    end else if (par_clr) begin
      r_par_err <= 1'b0;
    end
  end

  assign out_valid   = (r_count != '0);
  assign out_ir      = r_q[r_rptr].ir;
  assign out_ac      = r_q[r_rptr].ac;
  assign out_dram_a  = r_q[r_rptr].dram_a;
  assign out_dram_b  = r_q[r_rptr].dram_b;
  assign out_dram_j  = r_q[r_rptr].dram_j;
  assign out_jrst0   = r_q[r_rptr].jrst0;
  assign out_par_bad = r_q[r_rptr].par_bad;
  assign par_err     = r_par_err;
  assign count       = r_count;

endmodule

// File: tb/tb_ir_dispatch_queue.sv
module tb_ir_dispatch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_ir;
  logic        en_io_jrst;
  logic        en_ac;
  logic        flush;
  logic        dw_en;
  logic [8:0]  dw_addr;
  logic [14:0] dw_data;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_ir;
  logic [3:0]  out_ac;
  logic [2:0]  out_dram_a;
  logic [2:0]  out_dram_b;
  logic [7:0]  out_dram_j;
  logic        out_jrst0;
  logic        out_par_bad;
  logic        par_err;
  logic        par_clr;
  logic [2:0]  count;

  ir_dispatch_queue #(
    .DEPTH          (DEPTH),
    .DRAM_ADDR_BITS (9),
    .DRAM_WIDTH     (15)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ir       (in_ir),
    .en_io_jrst  (en_io_jrst),
    .en_ac       (en_ac),
    .flush       (flush),
    .dw_en       (dw_en),
    .dw_addr     (dw_addr),
    .dw_data     (dw_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ir      (out_ir),
    .out_ac      (out_ac),
    .out_dram_a  (out_dram_a),
    .out_dram_b  (out_dram_b),
    .out_dram_j  (out_dram_j),
    .out_jrst0   (out_jrst0),
    .out_par_bad (out_par_bad),
    .par_err     (par_err),
    .par_clr     (par_clr),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ir;
    int ac;
    int a;
    int b;
    int j;
    bit jrst0;
    bit pb;
  } ent_t;

  ent_t q_m[$];
  ent_t s1_m;
  bit   s1v_m = 1'b0;
  bit   par_m = 1'b0;
  int   ram_m[512];
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Dispatch address from the octal digits of the opcode.
  function automatic int disp_addr(int ir, bit eio);
    int mid;
    if (eio && ((ir >> 10) & 7) == 7) begin
      mid = (((ir >> 6) & 15) != 0) ? 7 : ((ir >> 3) & 7);
      return 7 * 64 + mid * 8 + (ir & 7);
    end
    return (ir >> 4) & 511;
  endfunction

  function automatic ent_t mk_ent(int ir, bit eio, bit eac, int w);
    ent_t e;
    int   acf;
    int   hi;
    int   lo;
    bit   jrst;
    acf     = ir & 15;
    jrst    = eio && (((ir >> 4) & 511) == 'o254);
    e.ir    = ir;
    e.ac    = eac ? acf : 0;
    e.a     = (w >> 12) & 7;
    e.b     = (w >> 9) & 7;
    hi      = (w >> 4) & 15;
    if (jrst) hi = hi & 14;
    lo      = jrst ? (w & 15) : acf;
    e.j     = hi * 16 + lo;
    e.jrst0 = jrst && (acf == 0);
    e.pb    = ($countones(w & 'h7fff) % 2) == 0;
    return e;
  endfunction

  function automatic bit exp_ready();
    return !reset && !flush && !dw_en && (q_m.size() + int'(s1v_m) < DEPTH);
  endfunction

  // Reference model, advanced once per rising edge.
  initial forever begin
    bit   acc;
    ent_t nw;
    @(posedge clk);
    acc = in_valid && exp_ready();
    if (acc) nw = mk_ent(int'(in_ir), en_io_jrst, en_ac, ram_m[disp_addr(int'(in_ir), en_io_jrst)]);
    if (reset) par_m = 1'b0;
    else if (!flush && s1v_m && s1_m.pb) par_m = 1'b1;
    else if (par_clr) par_m = 1'b0;
    if (reset || flush) begin
      q_m.delete();
      s1v_m = 1'b0;
      if (reset) chk_en = 1'b1;
    end else begin
      if (out_ready && q_m.size() > 0) void'(q_m.pop_front());
      if (s1v_m) q_m.push_back(s1_m);
      s1v_m = acc;
      s1_m  = nw;
    end
    if (dw_en) ram_m[int'(dw_addr)] = int'(dw_data);
  end

  // Every-cycle comparison against the model.
  initial forever begin
    logic [33:0] e_head;
    @(negedge clk);
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(exp_ready()));
      chk("out_valid", 64'(out_valid), 64'(q_m.size() > 0));
      chk("count", 64'(count), 64'(q_m.size()));
      chk("par_err", 64'(par_err), 64'(par_m));
      if (q_m.size() > 0) begin
        e_head = {13'(q_m[0].ir), 4'(q_m[0].ac), 3'(q_m[0].a), 3'(q_m[0].b), 8'(q_m[0].j),
                  q_m[0].jrst0, q_m[0].pb};
        chk("head", 64'({out_ir, out_ac, out_dram_a, out_dram_b, out_dram_j, out_jrst0,
                         out_par_bad}), 64'(e_head));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic ram_wr(input int a, input int d);
    dw_en   = 1'b1;
    dw_addr = 9'(a);
    dw_data = 15'(d);
    step();
    dw_en   = 1'b0;
  endtask

  task automatic push_one(input logic [12:0] ir, input bit eio, input bit eac);
    in_valid   = 1'b1;
    in_ir      = ir;
    en_io_jrst = eio;
    en_ac      = eac;
    step();
    in_valid   = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  localparam logic [14:0] W254 = 15'b101_010_0_1111_1010;
  localparam logic [14:0] WA   = 15'b011_100_0_0000_0000;
  localparam logic [14:0] WB   = 15'b110_001_0_0000_0000;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_ir = '0; en_io_jrst = 1'b0; en_ac = 1'b0;
    flush = 1'b0; dw_en = 1'b0; dw_addr = '0; dw_data = '0; out_ready = 1'b0;
    par_clr = 1'b0;
    step();
    step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;

    for (int a = 0; a < 512; a++) ram_wr(a, int'($urandom_range(0, 'h7fff)));

    // JRST with AC=0
    ram_wr('o254, int'(W254));
    push_one({9'o254, 4'd0}, 1'b1, 1'b1);
    chk("jrst_n1_valid", 64'(out_valid), 64'd0);
    step();
    chk("jrst_n2_valid", 64'(out_valid), 64'd1);
    chk("jrst_jrst0", 64'(out_jrst0), 64'd1);
    chk("jrst_dram_j", 64'(out_dram_j), 64'hEA);
    chk("jrst_dram_a", 64'(out_dram_a), 64'd5);
    chk("jrst_par_bad", 64'(out_par_bad), 64'd0);
    pop_one();

    // 7xx remap versus plain opcode addressing
    ram_wr('o775, int'(WA));
    ram_wr('o712, int'(WB));
    push_one({9'o712, 4'b1101}, 1'b1, 1'b1);
    step();
    chk("io_dram_a", 64'(out_dram_a), 64'd3);
    chk("io_dram_b", 64'(out_dram_b), 64'd4);
    chk("io_dram_j", 64'(out_dram_j), 64'h0D);
    chk("io_ac", 64'(out_ac), 64'd13);
    pop_one();
    push_one({9'o712, 4'b1101}, 1'b0, 1'b0);
    step();
    chk("plain_dram_a", 64'(out_dram_a), 64'd6);
    chk("plain_ac", 64'(out_ac), 64'd0);
    pop_one();

    // Even parity word
    ram_wr(5, 0);
    push_one({9'd5, 4'd0}, 1'b0, 1'b0);
    step();
    chk("par_bad", 64'(out_par_bad), 64'd1);
    chk("par_err_set", 64'(par_err), 64'd1);
    pop_one();
    step();
    chk("par_err_sticky", 64'(par_err), 64'd1);
    par_clr = 1'b1;
    step();
    par_clr = 1'b0;
    chk("par_err_clr", 64'(par_err), 64'd0);

    // Fill beyond DEPTH with the consumer stalled
    en_io_jrst = 1'b0;
    in_valid   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_ir = 13'(100 + i);
      step();
    end
    in_valid = 1'b0;
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head", 64'(out_ir), 64'd100);
    pop_one();
    chk("fifo_second", 64'(out_ir), 64'd101);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b0;

    // Flush with three queued and one in S1
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_ir = 13'(200 + i);
      step();
    end
    in_valid = 1'b0;
    chk("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    push_one(13'd300, 1'b0, 1'b0);
    chk("post_flush_n1", 64'(out_valid), 64'd0);
    step();
    chk("post_flush_n2", 64'(out_valid), 64'd1);
    chk("post_flush_ir", 64'(out_ir), 64'd300);
    pop_one();

    // Reset mid-operation
    push_one({9'd5, 4'd0}, 1'b0, 1'b0);
    push_one(13'd400, 1'b0, 1'b0);
    step();
    chk("pre_rst_count", 64'(count), 64'd2);
    chk("pre_rst_par", 64'(par_err), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_par", 64'(par_err), 64'd0);
    push_one({9'o254, 4'd0}, 1'b1, 1'b0);
    step();
    chk("ram_kept", 64'(out_dram_j), 64'hEA);
    pop_one();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic [12:0] r;
      int          sel;
      r   = 13'($urandom);
      sel = int'($urandom_range(0, 3));
      if (sel == 0) r[12:4] = 9'o254;
      else if (sel == 1) r[12:10] = 3'o7;
      in_valid   = ($urandom_range(0, 3) != 0);
      in_ir      = r;
      en_io_jrst = ($urandom_range(0, 3) != 0);
      en_ac      = $urandom_range(0, 1) != 0;
      out_ready  = ((c / 64) % 3 == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 49) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      par_clr    = ($urandom_range(0, 29) == 0);
      dw_en      = ($urandom_range(0, 19) == 0);
      dw_addr    = 9'($urandom);
      dw_data    = 15'($urandom);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0; par_clr = 1'b0; dw_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ir_dispatch_queue.md
IR_DISPATCH_QUEUE -- requirements
Module: ir_dispatch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; power of 2, at least 2.
REQ-002 SHALL have parameter DRAM_ADDR_BITS, default 9, meaning dispatch RAM address width (512 words).
REQ-003 SHALL have parameter DRAM_WIDTH, default 15, meaning dispatch word {A[0:2],B[0:2],P,J[1:4],J[7:10]}.
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  instruction word offered.
- in_ready  out  1  word accepted when in_valid&in_ready.
- in_ir  in  13  IR[0:12], opcode+AC.
- en_io_jrst  in  1  enables 7xx remap and JRST detect.
- en_ac  in  1  enables AC field; else AC=0.
- flush  in  1  discard all queued/in-flight entries.
- dw_en  in  1  dispatch RAM write strobe.
- dw_addr  in  DRAM_ADDR_BITS  write address.
- dw_data  in  DRAM_WIDTH  write data.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer pops head when out_valid&out_ready.
- out_ir  out  13  head IR[0:12].
- out_ac  out  4  head AC.
- out_dram_a  out  3  head DRAM A.
- out_dram_b  out  3  head DRAM B.
- out_dram_j  out  8  head {J[1:4],J[7:10]}.
- out_jrst0  out  1  head is JRST with AC=0.
- out_par_bad  out  1  head dispatch word had even parity.
- par_err  out  1  sticky parity error.
- par_clr  in  1  clears par_err.
- count  out  $clog2(DEPTH+1)  queued entries.

Function
REQ-005 Dispatch address SHALL be IR[0:8], except when IR[0:2]=7 and en_io_jrst: addr[3:5]={3{IR[3:6]!=0}}|IR[7:9], addr[6:8]=IR[10:12].
REQ-006 Accepted word SHALL go to stage S1 (IR, en flags registered), with synchronous RAM read; S1 result SHALL enter queue tail next cycle.
REQ-007 Latency: word accepted at cycle N with queue empty SHALL give out_valid at N+2.
REQ-008 JRST=en_io_jrst&(IR[0:8]=254 octal); when JRST, J[4] forced 0 and J[7:10] from RAM; else J[7:10]=IR[9:12].
REQ-009 out_jrst0 SHALL be JRST&(IR[9:12]=0); out_ac=en_ac?IR[9:12]:0, both captured at S1.
REQ-010 Entry SHALL set out_par_bad when XOR of all 15 RAM bits is 0; same cycle par_err SHALL set; par_clr clears it, set wins over simultaneous clear.
REQ-011 in_ready SHALL be ~reset & ~flush & ~dw_en & (count+S1valid < DEPTH); a pop in the same cycle SHALL NOT raise in_ready.
REQ-012 Simultaneous S1 enqueue and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-013 Pop with out_valid=0 SHALL be ignored; outputs SHALL hold stable while out_valid&~out_ready.
REQ-014 flush SHALL clear queue and S1 at next edge; count=0, out_valid=0 the following cycle; par_err unaffected.
REQ-015 dw_en SHALL write RAM at next edge; an S1 already in flight completes with the data read before the write.

Reset
REQ-016 Reset SHALL force out_valid=0, count=0, par_err=0, S1 invalid, pointers 0, in_ready=0 during reset; RAM contents SHALL NOT be cleared.
REQ-017 Reset mid-operation SHALL discard all entries, identically to flush.

Structure
REQ-018 Shared package ir_pkg SHALL hold DRAM_WIDTH, dispatch field offsets, dram_word_t and ir_entry_t structs, JRST opcode constant.
REQ-019 Dispatch RAM SHALL be sub-module ir_dram_ram (sync 1R1W, write priority); queue inline.

Verification
REQ-020 RAM[254]=odd-parity word J[1:4]=1111; push IR=254,AC=0 -> N+2 out_jrst0=1, out_dram_j[1:4]=1110, J[7:10]=RAM.
REQ-021 Push IR[0:12]=7,0,3,5 octal-split with IR[3:6]!=0 -> RAM addr 7,7|IR[7:9],IR[10:12] read; en_io_jrst=0 -> addr=IR[0:8].
REQ-022 DEPTH=4, out_ready=0, push 6 -> 4 stored, in_ready=0, count=4; then pop 1 per cycle -> FIFO order preserved.
REQ-023 Even-parity RAM word pushed -> out_par_bad=1, par_err=1 sticky until par_clr.
REQ-024 Queue holds 3, S1 valid, assert flush -> next cycle count=0, out_valid=0; then push -> out_valid 2 cycles later.
REQ-025 Reset asserted with count=2 -> next cycle count=0, out_valid=0, par_err=0; RAM data readable unchanged afterwards.
